// File: rtl/pattern_latch_fsm.sv
//==============================================================================
// Module      : pattern_latch_fsm
// Description : Debounced set/clear pattern latch with edge pulses and a
//               saturating activation counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pattern_latch_fsm #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] SET_PAT     = 3'b011,
    parameter logic [WIDTH-1:0] CLR_PAT     = 3'b100,
    parameter int               HOLD_CYCLES = 1,
    parameter int               CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] act_count,
    output logic [1:0]       state_dbg
);

    localparam int HCNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HCNT_W-1:0] c_HOLD = HCNT_W'(HOLD_CYCLES);

    generate
        if (SET_PAT == CLR_PAT) begin : g_bad_pat
            $error("pattern_latch_fsm: SET_PAT and CLR_PAT must differ");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("pattern_latch_fsm: HOLD_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_DISARMING = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HCNT_W-1:0]  r_hcnt;
    logic [HCNT_W-1:0]  w_hcnt_nxt;
    logic [HCNT_W-1:0]  w_hcnt_inc;
    logic               w_hold_done;
    logic               w_is_set;
    logic               w_is_clr;
    logic               w_rise_nxt;
    logic               w_fall_nxt;
    logic               r_rise;
    logic               r_fall;
    logic [CNT_W-1:0]   r_act_count;

    assign w_is_set    = (in == SET_PAT);
    assign w_is_clr    = (in == CLR_PAT);
    assign w_hcnt_inc  = r_hcnt + 1'b1;
    assign w_hold_done = (w_hcnt_inc == c_HOLD);

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hcnt_nxt = '0;
                if (w_is_set) begin
                    if (HOLD_CYCLES == 1) begin
                        w_state_nxt = ST_ACTIVE;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_ARMING;
                        w_hcnt_nxt  = HCNT_W'(1);
                    end
                end
            end
            ST_ARMING: begin
                if (w_is_set) begin
                    if (w_hold_done) begin
                        w_state_nxt = ST_ACTIVE;
                        w_hcnt_nxt  = '0;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_hcnt_nxt  = w_hcnt_inc;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = '0;
                end
            end
            ST_ACTIVE: begin
                w_hcnt_nxt = '0;
                if (w_is_clr) begin
                    if (HOLD_CYCLES == 1) begin
                        w_state_nxt = ST_IDLE;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DISARMING;
                        w_hcnt_nxt  = HCNT_W'(1);
                    end
                end
            end
            default: begin
                if (w_is_clr) begin
                    if (w_hold_done) begin
                        w_state_nxt = ST_IDLE;
                        w_hcnt_nxt  = '0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_hcnt_nxt  = w_hcnt_inc;
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                    w_hcnt_nxt  = '0;
                end
            end
        endcase
    end

    // Disabled cycles freeze progress but still retire any pending pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hcnt      <= '0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_act_count <= '0;
        end else if (enable) begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            if (w_rise_nxt && (r_act_count != '1)) begin
                r_act_count <= r_act_count + 1'b1;
            end
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign out       = (r_state == ST_ACTIVE) || (r_state == ST_DISARMING);
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign act_count = r_act_count;
    assign state_dbg = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pattern_latch_fsm.sv
//==============================================================================
// Module      : tb_pattern_latch_fsm
// Description : Scoreboard bench for pattern_latch_fsm across three configs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pattern_latch_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] din = 3'b000;

    always #5 clk = ~clk;

    logic       a_out, a_rise, a_fall;
    logic [7:0] a_cnt;
    logic [1:0] a_st;
    logic       b_out, b_rise, b_fall;
    logic [7:0] b_cnt;
    logic [1:0] b_st;
    logic       c_out, c_rise, c_fall;
    logic [1:0] c_cnt;
    logic [1:0] c_st;

    pattern_latch_fsm #(.HOLD_CYCLES(1)) u_hold1 (
        .clock(clk), .reset(rst), .enable(en), .in(din),
        .out(a_out), .rise(a_rise), .fall(a_fall), .act_count(a_cnt), .state_dbg(a_st)
    );

    pattern_latch_fsm #(.HOLD_CYCLES(3)) u_hold3 (
        .clock(clk), .reset(rst), .enable(en), .in(din),
        .out(b_out), .rise(b_rise), .fall(b_fall), .act_count(b_cnt), .state_dbg(b_st)
    );

    pattern_latch_fsm #(.HOLD_CYCLES(1), .CNT_W(2)) u_sat (
        .clock(clk), .reset(rst), .enable(en), .in(din),
        .out(c_out), .rise(c_rise), .fall(c_fall), .act_count(c_cnt), .state_dbg(c_st)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // exp layout: {state[1:0], out, rise, fall, act_count[7:0]}
    typedef struct packed {
        logic        rst;
        logic        en;
        logic [2:0]  in;
        logic [12:0] exp;
    } step_t;

    step_t       stim[$];
    logic [12:0] sb[$];

    function automatic void add(input logic r, input logic e, input logic [2:0] i,
                                input logic [1:0] st, input logic o, input logic ri,
                                input logic fa, input int cnt);
        stim.push_back({r, e, i, st, o, ri, fa, cnt[7:0]});
    endfunction

    function automatic logic [12:0] obs(input int d);
        case (d)
            0:       return {a_st, a_out, a_rise, a_fall, a_cnt};
            1:       return {b_st, b_out, b_rise, b_fall, b_cnt};
            default: return {c_st, c_out, c_rise, c_fall, 6'b0, c_cnt};
        endcase
    endfunction

    task automatic drive(input step_t s);
        @(negedge clk);
        rst = s.rst;
        en  = s.en;
        din = s.in;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t s; logic [12:0] e, o;
        add(1, 1, 3'b011, 0, 0, 0, 0, 0);
        add(1, 0, 3'b011, 0, 0, 0, 0, 0);
        for (int k = 0; stim.size() > 0; k++) begin
            s = stim.pop_front(); sb.push_back(s.exp); drive(s);
            e = sb.pop_front(); o = obs(0); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: {st,out,rise,fall,cnt} got %b expected %b", k, o, e);
            end
        end
    endtask

    task automatic test_hold1();
        step_t s; logic [12:0] e, o;
        add(1, 1, 3'b000, 0, 0, 0, 0, 0);
        add(0, 1, 3'b011, 2, 1, 1, 0, 1);
        add(0, 1, 3'b000, 2, 1, 0, 0, 1);
        add(0, 1, 3'b101, 2, 1, 0, 0, 1);
        add(0, 1, 3'b011, 2, 1, 0, 0, 1);
        add(0, 1, 3'b100, 0, 0, 0, 1, 1);
        add(0, 1, 3'b000, 0, 0, 0, 0, 1);
        add(0, 1, 3'b100, 0, 0, 0, 0, 1);
        for (int k = 0; stim.size() > 0; k++) begin
            s = stim.pop_front(); sb.push_back(s.exp); drive(s);
            e = sb.pop_front(); o = obs(0); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hold1 step %0d: {st,out,rise,fall,cnt} got %b expected %b", k, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s; logic [12:0] e, o;
        add(0, 1, 3'b011, 2, 1, 1, 0, 2);
        add(0, 1, 3'b100, 0, 0, 0, 1, 2);
        add(0, 1, 3'b011, 2, 1, 1, 0, 3);
        add(0, 0, 3'b100, 2, 1, 0, 0, 3);
        add(0, 1, 3'b100, 0, 0, 0, 1, 3);
        for (int k = 0; stim.size() > 0; k++) begin
            s = stim.pop_front(); sb.push_back(s.exp); drive(s);
            e = sb.pop_front(); o = obs(0); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: {st,out,rise,fall,cnt} got %b expected %b", k, o, e);
            end
        end
    endtask

    task automatic test_hold3_arm();
        step_t s; logic [12:0] e, o;
        add(1, 1, 3'b000, 0, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 1, 3'b000, 0, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 1, 3'b100, 0, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 1, 3'b011, 2, 1, 1, 0, 1);
        add(0, 1, 3'b000, 2, 1, 0, 0, 1);
        for (int k = 0; stim.size() > 0; k++) begin
            s = stim.pop_front(); sb.push_back(s.exp); drive(s);
            e = sb.pop_front(); o = obs(1); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hold3_arm step %0d: {st,out,rise,fall,cnt} got %b expected %b", k, o, e);
            end
        end
    endtask

    task automatic test_hold3_disarm();
        step_t s; logic [12:0] e, o;
        add(0, 1, 3'b011, 2, 1, 0, 0, 1);
        add(0, 1, 3'b100, 3, 1, 0, 0, 1);
        add(0, 1, 3'b100, 3, 1, 0, 0, 1);
        add(0, 1, 3'b111, 2, 1, 0, 0, 1);
        add(0, 1, 3'b100, 3, 1, 0, 0, 1);
        add(0, 1, 3'b100, 3, 1, 0, 0, 1);
        add(0, 1, 3'b100, 0, 0, 0, 1, 1);
        add(0, 1, 3'b000, 0, 0, 0, 0, 1);
        for (int k = 0; stim.size() > 0; k++) begin
            s = stim.pop_front(); sb.push_back(s.exp); drive(s);
            e = sb.pop_front(); o = obs(1); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hold3_disarm step %0d: {st,out,rise,fall,cnt} got %b expected %b", k, o, e);
            end
        end
    endtask

    task automatic test_enable();
        step_t s; logic [12:0] e, o;
        add(1, 1, 3'b000, 0, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 0, 3'b100, 1, 0, 0, 0, 0);
        add(0, 1, 3'b011, 2, 1, 1, 0, 1);
        add(0, 0, 3'b011, 2, 1, 0, 0, 1);
        add(0, 0, 3'b100, 2, 1, 0, 0, 1);
        add(0, 1, 3'b000, 2, 1, 0, 0, 1);
        for (int k = 0; stim.size() > 0; k++) begin
            s = stim.pop_front(); sb.push_back(s.exp); drive(s);
            e = sb.pop_front(); o = obs(1); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL enable step %0d: {st,out,rise,fall,cnt} got %b expected %b", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s; logic [12:0] e, o;
        add(1, 1, 3'b000, 0, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(1, 1, 3'b011, 0, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 1, 3'b011, 1, 0, 0, 0, 0);
        add(0, 1, 3'b011, 2, 1, 1, 0, 1);
        add(1, 1, 3'b100, 0, 0, 0, 0, 0);
        add(0, 1, 3'b000, 0, 0, 0, 0, 0);
        for (int k = 0; stim.size() > 0; k++) begin
            s = stim.pop_front(); sb.push_back(s.exp); drive(s);
            e = sb.pop_front(); o = obs(1); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: {st,out,rise,fall,cnt} got %b expected %b", k, o, e);
            end
        end
    endtask

    task automatic test_saturation();
        step_t s; logic [12:0] e, o;
        add(1, 1, 3'b000, 0, 0, 0, 0, 0);
        for (int n = 1; n <= 5; n++) begin
            add(0, 1, 3'b011, 2, 1, 1, 0, (n > 3) ? 3 : n);
            add(0, 1, 3'b100, 0, 0, 0, 1, (n > 3) ? 3 : n);
        end
        for (int k = 0; stim.size() > 0; k++) begin
            s = stim.pop_front(); sb.push_back(s.exp); drive(s);
            e = sb.pop_front(); o = obs(2); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL saturation step %0d: {st,out,rise,fall,cnt} got %b expected %b", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold1();
        test_back_to_back();
        test_hold3_arm();
        test_hold3_disarm();
        test_enable();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
